// File: rtl/btn_event_arbiter_if.sv
// Event handshake and status bundle between the button arbiter and its consumer.
// The arbiter attaches through the slave modport and the consumer through the master modport.
interface btn_event_arbiter_if #(
   parameter int N_BTN = 5
);
   localparam int ID_W = $clog2(N_BTN);

   logic [N_BTN-1:0] btn_raw;
   logic             evt_ack;
   logic             clr_overflow;
   logic             evt_valid;
   logic [ID_W-1:0]  evt_id;
   logic [N_BTN-1:0] pending;
   logic             overflow;

   modport slave (
      input  btn_raw, evt_ack, clr_overflow,
      output evt_valid, evt_id, pending, overflow
   );

   modport master (
      output btn_raw, evt_ack, clr_overflow,
      input  evt_valid, evt_id, pending, overflow
   );
endinterface

// File: rtl/btn_event_arbiter.sv
// Synchronises and debounces N_BTN raw buttons, latches their presses and presents them
// one at a time to a consumer, granting them in round-robin order with a valid/ack handshake.
module btn_event_arbiter #(
   parameter int N_BTN     = 5,
   parameter int DB_CYCLES = 500000
) (
   input  logic                clk,
   input  logic                reset,
   btn_event_arbiter_if.slave  evt_if
);

   localparam int ID_W  = $clog2(N_BTN);
   localparam int CNT_W = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DB_CYCLES - 1);
   localparam logic [ID_W-1:0]  LAST_IDX  = ID_W'(N_BTN - 1);

   typedef enum logic {
      IDLE,
      PRESENT
   } state_e;

   logic [N_BTN-1:0] sync1_q;
   logic [N_BTN-1:0] sync2_q;
   logic [N_BTN-1:0] stable_q;
   logic [N_BTN-1:0] stable_prev_q;
   logic [CNT_W-1:0] cnt_q [N_BTN];
   logic [N_BTN-1:0] pending_q;
   logic [N_BTN-1:0] pending_d;
   logic             overflow_q;
   logic             overflow_d;
   logic             evt_valid_q;
   logic [ID_W-1:0]  evt_id_q;
   logic [ID_W-1:0]  last_grant_q;
   state_e           state_q;

   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] above_mask;
   logic [N_BTN-1:0] masked_pend;
   logic [N_BTN-1:0] grant_vec;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_en;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the debounce counters are per-button state, not bulk storage, so they are reset too.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
         for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q       <= evt_if.btn_raw;
         sync2_q       <= sync1_q;
         stable_prev_q <= stable_q;
         for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
               if (cnt_q[i] == CNT_MAX) begin
                  stable_q[i] <= sync2_q[i];
                  cnt_q[i]    <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + CNT_W'(1);
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   // Round-robin pick: lowest pending bit above last_grant, else wrap to the lowest overall.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      rise      = stable_q & ~stable_prev_q;
      grant_idx = '0;
      for (int i = 0; i < N_BTN; i++) above_mask[i] = (ID_W'(i) > last_grant_q);
      masked_pend = pending_q & above_mask;
      if (masked_pend != '0) begin
         for (int i = N_BTN - 1; i >= 0; i--) if (masked_pend[i]) grant_idx = ID_W'(i);
      end else begin
         for (int i = N_BTN - 1; i >= 0; i--) if (pending_q[i]) grant_idx = ID_W'(i);
      end
   end

   always_comb begin
      grant_en  = (state_q == IDLE) && (pending_q != '0);
      grant_vec = '0;
      for (int i = 0; i < N_BTN; i++) grant_vec[i] = grant_en && (grant_idx == ID_W'(i));
      // A new press wins over a same-cycle grant of that bit; a press onto an ungranted one is lost.
      pending_d  = (pending_q & ~grant_vec) | rise;
      overflow_d = ((rise & pending_q & ~grant_vec) != '0) || (overflow_q && !evt_if.clr_overflow);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q    <= '0;
         overflow_q   <= 1'b0;
         state_q      <= IDLE;
         evt_valid_q  <= 1'b0;
         evt_id_q     <= '0;
         last_grant_q <= LAST_IDX;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         case (state_q)
            IDLE: begin
               if (grant_en) begin
                  evt_id_q     <= grant_idx;
                  last_grant_q <= grant_idx;
                  evt_valid_q  <= 1'b1;
                  state_q      <= PRESENT;
               end
            end
            PRESENT: begin
               if (evt_if.evt_ack) begin
                  evt_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign evt_if.evt_valid = evt_valid_q;
   assign evt_if.evt_id    = evt_id_q;
   assign evt_if.pending   = pending_q;
   assign evt_if.overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: directed scenarios plus randomized stimulus, every cycle
// compared against a cycle-level behavioural model of the button/arbiter rules.
module tb_btn_event_arbiter;

   localparam int N    = 5;
   localparam int DB   = 4;
   localparam int ID_W = $clog2(N);

   logic clk = 1'b0;
   logic reset;

   btn_event_arbiter_if #(.N_BTN(N)) bus ();

   btn_event_arbiter #(.N_BTN(N), .DB_CYCLES(DB)) dut (
      .clk    (clk),
      .reset  (reset),
      .evt_if (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: per-button arrays and plain integers.
   bit m_s1   [N];
   bit m_s2   [N];
   bit m_stab [N];
   bit m_prev [N];
   bit m_pend [N];
   int m_run  [N];
   bit m_valid;
   bit m_ovf;
   int m_id;
   int m_last;

   function automatic logic [31:0] pend_vec();
      logic [31:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_edge(input bit rst, input logic [N-1:0] raw, input bit ack, input bit clr);
      bit rise [N];
      int g;
      bit lost;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_prev[i] = 0; m_pend[i] = 0; m_run[i] = 0;
         end
         m_valid = 0; m_ovf = 0; m_id = 0; m_last = N - 1;
         return;
      end
      for (int i = 0; i < N; i++) begin
         rise[i]   = m_stab[i] && !m_prev[i];
         m_prev[i] = m_stab[i];
         if (m_s2[i] != m_stab[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_stab[i] = m_s2[i];
               m_run[i]  = 0;
            end
         end else begin
            m_run[i] = 0;
         end
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
      end
      g = -1;
      if (!m_valid) begin
         for (int k = 1; k <= N; k++) begin
            if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
         end
      end
      lost = 0;
      for (int i = 0; i < N; i++) begin
         if (rise[i] && m_pend[i] && i != g) lost = 1;
         if (i == g) m_pend[i] = 0;
         if (rise[i]) m_pend[i] = 1;
      end
      if (lost) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (m_valid) begin
         if (ack) m_valid = 0;
      end else if (g >= 0) begin
         m_valid = 1; m_id = g; m_last = g;
      end
   endtask

   task automatic compare();
      check("evt_valid", bus.evt_valid, m_valid);
      check("evt_id",    bus.evt_id,    m_id);
      check("pending",   bus.pending,   pend_vec());
      check("overflow",  bus.overflow,  m_ovf);
   endtask

   // Drive inputs at the falling edge, advance one rising edge, compare at the next falling edge.
   task automatic step(input logic [N-1:0] raw, input bit ack, input bit clr, input bit rst);
      bus.btn_raw      = raw;
      bus.evt_ack      = ack;
      bus.clr_overflow = clr;
      reset            = rst;
      model_edge(rst, raw, ack, clr);
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic hold(input logic [N-1:0] raw, input int n);
      for (int k = 0; k < n; k++) step(raw, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_event(input logic [N-1:0] raw, input int exp_id, input string tag);
      int budget = 30;
      while (!bus.evt_valid && budget > 0) begin
         step(raw, 1'b0, 1'b0, 1'b0);
         budget--;
      end
      check({tag, "_valid"}, bus.evt_valid, 1);
      check({tag, "_id"}, bus.evt_id, exp_id);
      step(raw, 1'b1, 1'b0, 1'b0);
      check({tag, "_drop"}, bus.evt_valid, 0);
   endtask

   initial begin
      int exp_ids [3] = '{0, 2, 4};
      int budget;
      bit seen;
      logic [N-1:0] raw;
      int seg;

      reset = 1'b1;
      bus.btn_raw = '0; bus.evt_ack = 1'b0; bus.clr_overflow = 1'b0;
      @(negedge clk);
      step('0, 0, 0, 1);
      step('0, 0, 0, 1);
      check("rst_valid",   bus.evt_valid, 0);
      check("rst_pending", bus.pending,   0);
      check("rst_ovf",     bus.overflow,  0);

      // Single press latency: rise before edge 1, pending at edge 7, event at edge 8.
      hold(5'b00100, 6);
      check("lat_pend_e6", bus.pending, 0);
      hold(5'b00100, 1);
      check("lat_pend_e7",  bus.pending,   5'b00100);
      check("lat_valid_e7", bus.evt_valid, 0);
      hold(5'b00100, 1);
      check("lat_valid_e8", bus.evt_valid, 1);
      check("lat_id_e8",    bus.evt_id,    2);
      check("lat_pend_e8",  bus.pending,   0);
      step(5'b00100, 1, 0, 0);
      check("lat_ack_drop", bus.evt_valid, 0);
      check("lat_ack_pend", bus.pending,   0);
      hold('0, 10);

      // Bounce shorter than the debounce window is rejected.
      step('0, 0, 0, 1);
      hold(5'b00001, 3);
      hold('0, 12);
      check("bounce_pend",  bus.pending,   0);
      check("bounce_valid", bus.evt_valid, 0);
      check("bounce_ovf",   bus.overflow,  0);

      // Round-robin from reset.
      step('0, 0, 0, 1);
      expect_event(5'b01010, 1, "rr_a");
      expect_event(5'b01010, 3, "rr_b");
      hold('0, 10);
      expect_event(5'b10001, 4, "rr_c");
      expect_event(5'b10001, 0, "rr_d");
      hold('0, 10);

      // Repeated presses of one button with no ack: first is granted, second latched, third lost.
      step('0, 0, 0, 1);
      hold(5'b00100, 6);
      hold('0, 6);
      hold(5'b00100, 6);
      hold('0, 6);
      check("ovf_pend2",  bus.pending[2], 1);
      check("ovf_before", bus.overflow,   0);
      hold(5'b00100, 6);
      hold('0, 6);
      check("ovf_set", bus.overflow, 1);
      step('0, 0, 1, 0);
      check("ovf_clr", bus.overflow, 0);

      // Reset while presenting with another press pending.
      step('0, 0, 0, 1);
      budget = 30;
      while (!bus.evt_valid && budget > 0) begin
         step(5'b10001, 0, 0, 0);
         budget--;
      end
      check("rst_pres_valid", bus.evt_valid, 1);
      check("rst_pres_pend",  bus.pending,   5'b10000);
      step('0, 0, 0, 1);
      check("rst_pres_drop",  bus.evt_valid, 0);
      check("rst_pres_clear", bus.pending,   0);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         step('0, 0, 0, 0);
         if (bus.evt_valid) seen = 1;
      end
      check("rst_pres_none", seen, 0);

      // Ack tied high: valid alternates, ids follow round-robin order.
      step('0, 1, 0, 1);
      budget = 30;
      while (!bus.evt_valid && budget > 0) begin
         step(5'b10101, 1, 0, 0);
         budget--;
      end
      check("tput_first", bus.evt_valid, 1);
      check("tput_id0",   bus.evt_id,    exp_ids[0]);
      for (int k = 1; k <= 4; k++) begin
         step(5'b10101, 1, 0, 0);
         check("tput_valid", bus.evt_valid, (k % 2 == 0) ? 1 : 0);
         if (k % 2 == 0) check("tput_id", bus.evt_id, exp_ids[k / 2]);
      end
      hold('0, 10);

      // Randomized stimulus against the model.
      step('0, 0, 0, 1);
      raw = '0;
      seg = 0;
      for (int c = 0; c < 4000; c++) begin
         if (seg == 0) begin
            raw = N'($urandom);
            seg = $urandom_range(1, 10);
         end
         seg--;
         step(raw, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 299) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
